axis_dvp: RTL and testbench
===========================

AXIS_DVP -- requirements
Module: axis_dvp

Interface
REQ-001 SHALL provide parameter WIDTH_P, default 8, pixel data width in bits; must be a multiple of 8.
REQ-002 SHALL provide parameter H_ACTIVE_P, default 640, pixels per line.
REQ-003 SHALL provide parameter H_BLANK_P, default 16, blanking cycles after each line.
REQ-004 SHALL provide parameter V_ACTIVE_P, default 480, lines per frame.
REQ-005 SHALL provide parameters VSYNC_P, VBP_P and VFP_P, defaults 4, 8 and 8: vsync pulse, back porch and front porch lengths, all in pclk cycles.
REQ-006 SHALL provide ports:
- pclk_i  input  1  pixel clock; the single clock for all logic.
- rst_i  input  1  reset; asynchronous, active-high.
- tdata_i  input  WIDTH_P  stream payload.
- tkeep_i  input  WIDTH_P/8  byte qualifier; ignored.
- tlast_i  input  1  end-of-line marker.
- tvalid_i  input  1  payload valid.
- tready_o  output  1  block ready.
- vsync_o  output  1  frame sync.
- hsync_o  output  1  line valid.
- data_o  output  WIDTH_P  pixel byte.
- err_o  output  2  sticky error flags: bit0 underflow, bit1 tlast mismatch.

Function
REQ-007 SHALL implement an FSM with states IDLE, VSYNC, VBP, ACTIVE, HBLANK and VFP, plus a horizontal counter and a vertical line counter.
REQ-008 IDLE SHALL go to VSYNC on the first cycle tvalid_i=1; no beat is consumed in IDLE.
REQ-009 VSYNC SHALL last VSYNC_P cycles, then go to VBP; VBP SHALL last VBP_P cycles, then go to ACTIVE with the line counter at 0.
REQ-010 ACTIVE SHALL last exactly H_ACTIVE_P cycles, then go to HBLANK.
REQ-011 HBLANK SHALL last H_BLANK_P cycles, then go to ACTIVE if more lines remain, else to VFP.
REQ-012 VFP SHALL last VFP_P cycles, then go to VSYNC; frames repeat with no return to IDLE.
REQ-013 tready_o SHALL be combinationally 1 only in ACTIVE.
REQ-014 Each ACTIVE cycle SHALL produce one output pixel regardless of tvalid_i; the line never stalls.
REQ-015 Outputs SHALL be registered with 1-cycle latency: vsync_o=1 the cycle after each VSYNC-state cycle; hsync_o=1 the cycle after each ACTIVE cycle.
REQ-016 data_o SHALL be tdata_i of the beat accepted in the previous cycle; on an underflow cycle it SHALL be 0.
REQ-017 data_o SHALL be 0 whenever hsync_o=0.
REQ-018 Underflow SHALL be an ACTIVE cycle with tvalid_i=0; it SHALL set err_o[0].
REQ-019 tlast mismatch SHALL be an accepted beat with tlast_i=1 on a non-final pixel, or tlast_i=0 on the final pixel (counter = H_ACTIVE_P-1); it SHALL set err_o[1].
REQ-020 err_o bits SHALL stay set until reset.
REQ-021 Counters SHALL size to $clog2 of their maximum count and wrap to 0 on each state exit.
REQ-022 A tlast_i=1 beat SHALL NOT end a line early; timing follows the counters only.

Reset
REQ-023 rst_i=1 SHALL asynchronously force IDLE, clear all counters and set vsync_o=0, hsync_o=0, data_o=0, err_o=0 and tready_o=0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait in IDLE for tvalid_i.

Configuration
REQ-025 With macro AXIS_DVP_ERR_EN defined, the err_o detection logic of REQ-018..REQ-020 SHALL be compiled in.
REQ-026 Without AXIS_DVP_ERR_EN, err_o SHALL be constant 0 and all other behaviour SHALL be unchanged.

Verification (H_ACTIVE_P=4, H_BLANK_P=2, V_ACTIVE_P=2, VSYNC_P=2, VBP_P=2, VFP_P=2)
REQ-027 Reset then tvalid_i=1 held -> vsync_o high for 2 cycles, 2 gap cycles, then hsync_o high for 4 cycles, low for 2, high for 4.
REQ-028 Pixel stream 0x10..0x17 with tlast_i on the 4th and 8th beats -> data_o 0x10..0x13 on line 0 and 0x14..0x17 on line 1; err_o=0.
REQ-029 tvalid_i dropped on the 2nd beat of a line -> hsync_o still high 4 cycles, that pixel's data_o=0x00, err_o[0]=1 and stays set.
REQ-030 tlast_i=1 on the 2nd beat -> err_o[1]=1, line length still 4.
REQ-031 rst_i pulsed mid-line -> all outputs 0 immediately; the next frame starts with vsync_o after tvalid_i.
REQ-032 AXIS_DVP_ERR_EN undefined and REQ-029 stimulus applied -> err_o stays 0, identical timing.

Source files
------------

// File: rtl/axis_dvp.sv
// axis_dvp: AXI-Stream to DVP video timing bridge with registered sync/pixel outputs.
// Define AXIS_DVP_ERR_EN to compile in sticky underflow / tlast-mismatch detection on err_o.
module axis_dvp #(
  parameter int WIDTH_P    = 8,
  parameter int H_ACTIVE_P = 640,
  parameter int H_BLANK_P  = 16,
  parameter int V_ACTIVE_P = 480,
  parameter int VSYNC_P    = 4,
  parameter int VBP_P      = 8,
  parameter int VFP_P      = 8
) (
  input  logic               pclk_i,
  input  logic               rst_i,
  input  logic [WIDTH_P-1:0] tdata_i,
  input  logic [WIDTH_P/8-1:0] tkeep_i,
  input  logic               tlast_i,
  input  logic               tvalid_i,
  output logic               tready_o,
  output logic               vsync_o,
  output logic               hsync_o,
  output logic [WIDTH_P-1:0] data_o,
  output logic [1:0]         err_o
);
  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP} state_t;
  localparam int M1 = H_ACTIVE_P > H_BLANK_P ? H_ACTIVE_P : H_BLANK_P;
  localparam int M2 = M1 > VSYNC_P ? M1 : VSYNC_P;
  localparam int M3 = M2 > VBP_P ? M2 : VBP_P;
  localparam int H_MAX = M3 > VFP_P ? M3 : VFP_P;
  localparam int HW = H_MAX > 1 ? $clog2(H_MAX) : 1;
  localparam int VW = V_ACTIVE_P > 1 ? $clog2(V_ACTIVE_P) : 1;
  state_t state, state_n;
  logic [HW-1:0] h_cnt, h_end;
  logic [VW-1:0] v_cnt;
  logic h_last, v_last, unused;
  assign unused = ^{tkeep_i, tlast_i};
  // one shared horizontal counter times every non-idle state against its own length
  always_comb begin
    h_end = state == VSYNC ? HW'(VSYNC_P - 1) :
            state == VBP ? HW'(VBP_P - 1) :
            state == ACTIVE ? HW'(H_ACTIVE_P - 1) :
            state == HBLANK ? HW'(H_BLANK_P - 1) : HW'(VFP_P - 1);
    h_last = state != IDLE && h_cnt == h_end;
    v_last = v_cnt == VW'(V_ACTIVE_P - 1);
    state_n = state == IDLE ? (tvalid_i ? VSYNC : IDLE) :
              !h_last ? state :
              state == VSYNC ? VBP :
              state == VBP ? ACTIVE :
              state == ACTIVE ? HBLANK :
              state == HBLANK ? (v_last ? VFP : ACTIVE) : VSYNC;
  end
  assign tready_o = state == ACTIVE;
  always_ff @(posedge pclk_i or posedge rst_i)
    if (rst_i) begin
      state   <= IDLE;
      h_cnt   <= '0;
      v_cnt   <= '0;
      vsync_o <= 1'b0;
      hsync_o <= 1'b0;
      data_o  <= '0;
    end else begin
      state   <= state_n;
      h_cnt   <= (h_last || state == IDLE) ? '0 : h_cnt + 1'b1;
      v_cnt   <= state == VBP ? '0 : (state == HBLANK && h_last) ? (v_last ? '0 : v_cnt + 1'b1) : v_cnt;
      vsync_o <= state == VSYNC;
      hsync_o <= state == ACTIVE;
      data_o  <= (state == ACTIVE && tvalid_i) ? tdata_i : '0;
    end
`ifdef AXIS_DVP_ERR_EN
  always_ff @(posedge pclk_i or posedge rst_i)
    if (rst_i) err_o <= '0;
    else if (state == ACTIVE) err_o <= err_o | {tvalid_i && (tlast_i != (h_cnt == HW'(H_ACTIVE_P - 1))), !tvalid_i};
`else
  assign err_o = '0;
`endif
endmodule

// File: tb/tb_axis_dvp.sv
// tb_axis_dvp: directed scoreboard bench for axis_dvp with a 4x2 frame and 2-cycle porches.
module tb_axis_dvp;
`ifdef AXIS_DVP_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  localparam logic [31:0] EV = 32'h0030_000C;
  localparam logic [31:0] EH = 32'h0000_F3C0;
  logic pclk_i = 1'b0, rst_i = 1'b0, tlast_i = 1'b0, tvalid_i = 1'b0;
  logic [7:0] tdata_i = '0;
  logic [0:0] tkeep_i = 1'b1;
  logic tready_o, vsync_o, hsync_o;
  logic [7:0] data_o;
  logic [1:0] err_o;
  int errors = 0, checks = 0;
  bit mon_en = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] e;
  logic [7:0] sd[8];
  bit sv[8], sl[8];
  always #5 pclk_i = ~pclk_i;
  axis_dvp #(.WIDTH_P(8), .H_ACTIVE_P(4), .H_BLANK_P(2), .V_ACTIVE_P(2),
             .VSYNC_P(2), .VBP_P(2), .VFP_P(2)) dut (
    .pclk_i(pclk_i), .rst_i(rst_i), .tdata_i(tdata_i), .tkeep_i(tkeep_i),
    .tlast_i(tlast_i), .tvalid_i(tvalid_i), .tready_o(tready_o),
    .vsync_o(vsync_o), .hsync_o(hsync_o), .data_o(data_o), .err_o(err_o));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  always @(negedge pclk_i)
    if (mon_en && !rst_i) begin
      if (hsync_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_pixel: got data %0h want no pixel", data_o);
        end else begin
          e = exp_q.pop_front();
          chk("pixel_data", {24'h0, data_o}, {24'h0, e[7:0]});
          chk("pixel_err", {30'h0, err_o}, {30'h0, e[9:8]});
        end
      end else chk("blank_data", {24'h0, data_o}, 32'h0);
    end
  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    chk("reset_outputs", {19'h0, vsync_o, hsync_o, data_o, err_o, tready_o}, 32'h0);
    tvalid_i = 1'b0;
    tlast_i = 1'b0;
    tdata_i = '0;
    exp_q.delete();
    repeat (2) @(negedge pclk_i);
    rst_i = 1'b0;
    mon_en = 1'b1;
    @(negedge pclk_i);
  endtask
  task automatic load(input logic [7:0] base, input int drop, input int lastpos);
    for (int i = 0; i < 8; i++) begin
      sd[i] = base + 8'(i);
      sv[i] = i != drop;
      sl[i] = (i % 4 == 3) || i == lastpos;
    end
  endtask
  task automatic run(input int ncyc, input int exp_slots);
    int n = 0;
    logic [1:0] ee = '0;
    logic [31:0] rv = '0, rh = '0, mask;
    tvalid_i = 1'b1;
    tdata_i = 8'hEE;
    tlast_i = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge pclk_i);
      rv[k] = vsync_o;
      rh[k] = hsync_o;
      if (tready_o && n < 8) begin
        tvalid_i = sv[n];
        tdata_i = sd[n];
        tlast_i = sl[n];
        if (ERR) ee = ee | {sv[n] && (sl[n] != (n % 4 == 3)), !sv[n]};
        exp_q.push_back({ee, sv[n] ? sd[n] : 8'h00});
        n++;
      end else begin
        tvalid_i = 1'b1;
        tdata_i = 8'hEE;
        tlast_i = 1'b0;
      end
    end
    mask = (32'd1 << (ncyc + 1)) - 32'd1;
    chk("vsync_pattern", rv, EV & mask);
    chk("hsync_pattern", rh, EH & mask);
    chk("slots_taken", n, exp_slots);
    if (ncyc > 16) begin
      chk("queue_drained", exp_q.size(), 0);
      chk("err_final", {30'h0, err_o}, {30'h0, ee});
    end
  endtask
  initial begin
    #3;
    do_reset();
    load(8'h10, -1, -1);
    run(22, 8);
    do_reset();
    load(8'h20, 1, -1);
    run(22, 8);
    do_reset();
    load(8'h30, -1, 1);
    run(22, 8);
    do_reset();
    load(8'h40, -1, -1);
    run(6, 2);
    #2;
    do_reset();
    repeat (3) begin
      @(negedge pclk_i);
      chk("idle_wait", {29'h0, vsync_o, hsync_o, tready_o}, 32'h0);
    end
    load(8'h50, -1, -1);
    run(22, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
